// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// One radix-2 shift-add or restoring-division step per cycle, then a sign-fix cycle.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam logic [2:0] OP_MUL  = 3'd1;
    localparam logic [2:0] OP_DIV  = 3'd2;
    localparam logic [2:0] OP_MTHI = 3'd3;
    localparam logic [2:0] OP_MTLO = 3'd4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_b_mag;
    logic [XLEN-1:0]     r_a_raw;
    logic                r_is_div;
    logic                r_neg_q;
    logic                r_neg_r;
    logic                r_dz;
    logic [XLEN-1:0]     r_hi;
    logic [XLEN-1:0]     r_lo;
    logic                r_done;
    logic                r_busy;
    logic                r_ready;

    logic                w_accept;
    logic                w_start;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_a_mag;
    logic [XLEN-1:0]     w_b_mag;
    logic [XLEN:0]       w_sum;
    logic [XLEN:0]       w_shift;
    logic [XLEN:0]       w_diff;
    logic [2*XLEN-1:0]   w_step;
    logic [2*XLEN-1:0]   w_prod_fix;
    logic [XLEN-1:0]     w_fix_hi;
    logic [XLEN-1:0]     w_fix_lo;
    logic [XLEN-1:0]     w_hi_next;
    logic [XLEN-1:0]     w_lo_next;

    assign w_accept = req_valid & r_ready & ~flush;
    assign w_start  = w_accept & ((req_op == OP_MUL) | (req_op == OP_DIV));
    assign w_a_neg  = ~req_unsigned & req_a[XLEN-1];
    assign w_b_neg  = ~req_unsigned & req_b[XLEN-1];
    assign w_a_mag  = w_a_neg ? (-req_a) : req_a;
    assign w_b_mag  = w_b_neg ? (-req_b) : req_b;

    // Next-state logic of the IDLE -> CALC -> FIX sequence
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_next_state = S_CALC;
                else         w_next_state = S_IDLE;
            end
            S_CALC: begin
                if (flush)                  w_next_state = S_IDLE;
                else if (r_cnt == CNT_LAST) w_next_state = S_FIX;
                else                        w_next_state = S_CALC;
            end
            S_FIX:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // One iteration step; r_acc holds {partial product, multiplier} or {remainder, quotient}
    always_comb begin
        w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b_mag} : {(XLEN+1){1'b0}});
        w_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
        w_diff  = w_shift - {1'b0, r_b_mag};
        w_step  = r_acc;
        if (r_is_div) begin
            // w_diff[XLEN] is the borrow: restore when the trial subtraction underflows
            if (w_diff[XLEN]) w_step = {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
            else              w_step = {w_diff[XLEN-1:0],  r_acc[XLEN-2:0], 1'b1};
        end else begin
            w_step = {w_sum, r_acc[XLEN-1:1]};
        end
    end

    // Sign correction and divide-by-zero override applied in FIX
    always_comb begin
        w_prod_fix = r_neg_q ? (-r_acc) : r_acc;
        w_fix_hi   = w_prod_fix[2*XLEN-1:XLEN];
        w_fix_lo   = w_prod_fix[XLEN-1:0];
        if (r_is_div) begin
            if (r_dz) begin
                w_fix_hi = r_a_raw;
                w_fix_lo = {XLEN{1'b1}};
            end else begin
                w_fix_hi = r_neg_r ? (-r_acc[2*XLEN-1:XLEN]) : r_acc[2*XLEN-1:XLEN];
                w_fix_lo = r_neg_q ? (-r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
            end
        end else begin
            w_fix_hi = w_prod_fix[2*XLEN-1:XLEN];
            w_fix_lo = w_prod_fix[XLEN-1:0];
        end
    end

    // HI/LO next value: MTHI/MTLO in IDLE, result in FIX unless flushed
    always_comb begin
        w_hi_next = r_hi;
        w_lo_next = r_lo;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (req_op == OP_MTHI))      w_hi_next = req_a;
                else if (w_accept && (req_op == OP_MTLO)) w_lo_next = req_a;
                else                                      w_hi_next = r_hi;
            end
            S_FIX: begin
                if (!flush) begin
                    w_hi_next = w_fix_hi;
                    w_lo_next = w_fix_lo;
                end else begin
                    w_hi_next = r_hi;
                end
            end
            default: w_hi_next = r_hi;
        endcase
    end

    // State, status flags and architectural HI/LO
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_hi    <= {XLEN{1'b0}};
            r_lo    <= {XLEN{1'b0}};
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_hi    <= w_hi_next;
            r_lo    <= w_lo_next;
            r_done  <= (r_state == S_FIX) & ~flush;
            r_busy  <= (w_next_state != S_IDLE);
            r_ready <= (w_next_state == S_IDLE);
        end
    end

    // Operand latch at accept and iteration datapath
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= {CNT_W{1'b0}};
            r_acc    <= {(2*XLEN){1'b0}};
            r_b_mag  <= {XLEN{1'b0}};
            r_a_raw  <= {XLEN{1'b0}};
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
        end else if ((r_state == S_IDLE) && w_start) begin
            r_cnt    <= {CNT_W{1'b0}};
            r_acc    <= {{XLEN{1'b0}}, w_a_mag};
            r_b_mag  <= w_b_mag;
            r_a_raw  <= req_a;
            r_is_div <= (req_op == OP_DIV);
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_dz     <= (req_b == {XLEN{1'b0}});
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            r_acc <= w_step;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign req_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; inputs driven and outputs sampled on negedges.
module tb_muldiv_unit;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic        req_unsigned;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests;
    int n_fail;

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_unsigned(req_unsigned),
        .req_a       (req_a),
        .req_b       (req_b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present a request for one cycle, then scramble operands to prove they were latched
    task automatic start_op(input logic [2:0] op, input logic uns, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        req_valid    = 1'b1;
        req_op       = op;
        req_unsigned = uns;
        req_a        = a;
        req_b        = b;
        @(negedge clock);
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_a     = 32'hA5A5_5A5A;
        req_b     = 32'h0F0F_F0F0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic uns,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        n = 0;
        start_op(op, uns, a, b);
        while (busy && n < 100) begin
            n++;
            @(negedge clock);
        end
        check_val({tag, " busy_cycles"}, 64'(n), 64'd33);
        check_val({tag, " done"}, 64'(done), 64'd1);
        check_val({tag, " hi"}, 64'(hi), {32'd0, exp_hi});
        check_val({tag, " lo"}, 64'(lo), {32'd0, exp_lo});
        @(negedge clock);
        check_val({tag, " done_once"}, 64'(done), 64'd0);
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        reset_n      = 1'b0;
        req_valid    = 1'b0;
        req_op       = 3'd0;
        req_unsigned = 1'b0;
        req_a        = 32'd0;
        req_b        = 32'd0;
        flush        = 1'b0;

        @(negedge clock);
        check_val("rst hi", 64'(hi), 64'd0);
        check_val("rst lo", 64'(lo), 64'd0);
        check_val("rst busy", 64'(busy), 64'd0);
        check_val("rst done", 64'(done), 64'd0);
        check_val("rst ready", 64'(req_ready), 64'd1);
        reset_n = 1'b1;

        run_op("umul_max", 3'd1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("smul_neg", 3'd1, 1'b0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("smul_min", 3'd1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("sdiv_m7_2", 3'd2, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("sdiv_7_m2", 3'd2, 1'b0, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        run_op("udiv_100_7", 3'd2, 1'b1, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("udiv_big", 3'd2, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'h7FFF_FFFF);
        run_op("sdiv_ovf", 3'd2, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_op("sdiv_dz", 3'd2, 1'b0, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
        run_op("udiv_dz", 3'd2, 1'b1, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);

        // Flush on the tenth CALC cycle
        start_op(3'd1, 1'b1, 32'd3, 32'd5);
        repeat (9) @(negedge clock);
        check_val("flush10 busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check_val("flush10 busy", 64'(busy), 64'd0);
        check_val("flush10 hi", 64'(hi), 64'h1234_5678);
        check_val("flush10 lo", 64'(lo), 64'hFFFF_FFFF);
        check_val("flush10 done", 64'(done), 64'd0);
        @(negedge clock);
        check_val("flush10 done_late", 64'(done), 64'd0);

        // Flush in the FIX cycle beats the write
        start_op(3'd1, 1'b1, 32'd3, 32'd5);
        repeat (32) @(negedge clock);
        check_val("flushfix busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check_val("flushfix busy", 64'(busy), 64'd0);
        check_val("flushfix hi", 64'(hi), 64'h1234_5678);
        check_val("flushfix lo", 64'(lo), 64'hFFFF_FFFF);
        check_val("flushfix done", 64'(done), 64'd0);
        @(negedge clock);
        check_val("flushfix done_late", 64'(done), 64'd0);

        // MTHI while idle is immediate with no busy period
        start_op(3'd3, 1'b0, 32'hDEAD_BEEF, 32'd0);
        check_val("mthi hi", 64'(hi), 64'hDEAD_BEEF);
        check_val("mthi lo", 64'(lo), 64'hFFFF_FFFF);
        check_val("mthi busy", 64'(busy), 64'd0);

        // MTLO held while a MUL is in flight
        start_op(3'd1, 1'b1, 32'd5, 32'd6);
        req_valid = 1'b1;
        req_op    = 3'd4;
        req_a     = 32'h0000_0055;
        @(negedge clock);
        check_val("mtlo_busy ready", 64'(req_ready), 64'd0);
        check_val("mtlo_busy lo", 64'(lo), 64'hFFFF_FFFF);
        begin
            int n;
            n = 0;
            while (!req_ready && n < 100) begin
                n++;
                @(negedge clock);
            end
            check_val("mtlo_busy wait", 64'(n), 64'd32);
        end
        check_val("mtlo_mul lo", 64'(lo), 64'd30);
        check_val("mtlo_mul done", 64'(done), 64'd1);
        @(negedge clock);
        req_valid = 1'b0;
        req_op    = 3'd0;
        check_val("mtlo lo", 64'(lo), 64'h55);
        check_val("mtlo hi", 64'(hi), 64'd0);

        // NONE op is accepted without effect
        start_op(3'd0, 1'b0, 32'h1111_1111, 32'd0);
        check_val("none lo", 64'(lo), 64'h55);
        check_val("none busy", 64'(busy), 64'd0);

        // Reset mid-DIV aborts immediately
        start_op(3'd2, 1'b1, 32'd100, 32'd7);
        repeat (5) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_val("rstmid hi", 64'(hi), 64'd0);
        check_val("rstmid lo", 64'(lo), 64'd0);
        check_val("rstmid busy", 64'(busy), 64'd0);
        check_val("rstmid ready", 64'(req_ready), 64'd1);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check_val("rstmid idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
